// File: rtl/qa_counter_unit.sv
// qa_counter_unit: up/down counter with wrap/saturate boundary mode, load, compare strobe and optional prescaler
//
// Ports:
//   sysClk        in   rising-edge system clock
//   sysReset      in   asynchronous active-high reset
//   enable        in   count enable; low holds count and prescaler
//   dirDown       in   0 = count up, 1 = count down
//   modeSaturate  in   0 = wrap at boundary, 1 = hold at boundary
//   load          in   synchronous load strobe, overrides counting
//   loadValue     in   [WIDTH]          value written on load
//   compareValue  in   [WIDTH]          match value for comparePulse
//   prescaleDiv   in   [PRESCALE_WIDTH] prescaler divisor minus one
//   count         out  [WIDTH]          registered counter value
//   terminalPulse out  one-cycle strobe after a tick taken at the boundary
//   comparePulse  out  one-cycle strobe after count is written with compareValue
//
// Build option: define QA_COUNTER_PRESCALER_EN to include the prescaler;
// without it every enabled cycle is a tick and prescaleDiv is ignored.
module qa_counter_unit #(
  parameter int WIDTH = 8,
  parameter int PRESCALE_WIDTH = 4
) (
  input  logic                      sysClk,
  input  logic                      sysReset,
  input  logic                      enable,
  input  logic                      dirDown,
  input  logic                      modeSaturate,
  input  logic                      load,
  input  logic [WIDTH-1:0]          loadValue,
  input  logic [WIDTH-1:0]          compareValue,
  input  logic [PRESCALE_WIDTH-1:0] prescaleDiv,
  output logic [WIDTH-1:0]          count,
  output logic                      terminalPulse,
  output logic                      comparePulse
);
  logic             w_tick;
  logic             w_boundary;
  logic [WIDTH-1:0] w_step;
  logic [WIDTH-1:0] w_next;
`ifdef QA_COUNTER_PRESCALER_EN
  logic [PRESCALE_WIDTH-1:0] r_pre;
  logic                      w_expired;
  assign w_expired = r_pre == prescaleDiv;
  assign w_tick = enable && w_expired;
  always_ff @(posedge sysClk or posedge sysReset) begin
    if (sysReset) r_pre <= '0;
    else if (load) r_pre <= '0;
    else if (enable) r_pre <= w_expired ? '0 : r_pre + PRESCALE_WIDTH'(1);
  end
`else
  logic w_unused_div;
  assign w_unused_div = ^prescaleDiv;
  assign w_tick = enable;
`endif
  assign w_boundary = dirDown ? (count == '0) : (count == '1);
  // modulo arithmetic already produces the wrapped value at the boundary
  assign w_step = dirDown ? count - WIDTH'(1) : count + WIDTH'(1);
  assign w_next = (w_boundary && modeSaturate) ? count : w_step;
  always_ff @(posedge sysClk or posedge sysReset) begin
    if (sysReset) begin
      count         <= '0;
      terminalPulse <= 1'b0;
      comparePulse  <= 1'b0;
    end else begin
      count         <= load ? loadValue : (w_tick ? w_next : count);
      terminalPulse <= !load && w_tick && w_boundary;
      comparePulse  <= load ? (loadValue == compareValue) : (w_tick && w_next == compareValue);
    end
  end
endmodule
